// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rx
// Purpose  : Write-only I2C target. Oversamples SCL/SDA on clk, detects
//            START/STOP, matches a 7-bit address, ACKs by pulling SDA low
//            and emits each received data byte with a 1-cycle strobe.
// Options  : I2C_GLITCH_FILTER_EN - adds a 3-sample stability filter on both
//            lines after the synchronizer (6 clk latency, clk >= 16x SCL).
//            Undefined: synced lines used directly (3 clk latency, clk >= 8x).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       addr_match,
    output logic       busy,
    output logic       stop_det
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_addr      = 3'd1;
    localparam logic [2:0] c_st_addr_ack  = 3'd2;
    localparam logic [2:0] c_st_data      = 3'd3;
    localparam logic [2:0] c_st_data_ack  = 3'd4;
    localparam logic [2:0] c_st_wait_stop = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    logic       r_scl_sync1, r_scl_sync2;
    logic       r_sda_sync1, r_sda_sync2;
    logic       w_scl, w_sda;
    logic       r_scl_hist, r_sda_hist;

    logic [3:0] r_bit_cnt;
    logic [7:0] r_sr;
    logic [7:0] w_sr_next;
    logic       r_sda_oe;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic       r_addr_match;
    logic       r_stop_det;
    logic       w_busy;

    logic       w_start, w_stop, w_scl_rise, w_scl_fall, w_byte_done;

    // Two-flop synchronizer for the asynchronous bus lines (idle-high on reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync1 <= 1'b1;
            r_scl_sync2 <= 1'b1;
            r_sda_sync1 <= 1'b1;
            r_sda_sync2 <= 1'b1;
        end else begin
            r_scl_sync1 <= scl_in;
            r_scl_sync2 <= r_scl_sync1;
            r_sda_sync1 <= sda_in;
            r_sda_sync2 <= r_sda_sync1;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] r_scl_win, r_sda_win;
    logic       r_scl_filt, r_sda_filt;

    // Filtered level follows the synced line only after 3 agreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_win  <= 2'b11;
            r_sda_win  <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_win <= {r_scl_win[0], r_scl_sync2};
            r_sda_win <= {r_sda_win[0], r_sda_sync2};
            if (r_scl_win == {2{r_scl_sync2}}) r_scl_filt <= r_scl_sync2;
            if (r_sda_win == {2{r_sda_sync2}}) r_sda_filt <= r_sda_sync2;
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync2;
    assign w_sda = r_sda_sync2;
`endif

    // History flops: previous internal line levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_start     = w_scl & r_sda_hist & ~w_sda;
    assign w_stop      = w_scl & ~r_sda_hist & w_sda;
    assign w_scl_rise  = w_scl & ~r_scl_hist;
    assign w_scl_fall  = ~w_scl & r_scl_hist;
    assign w_sr_next   = {r_sr[6:0], w_sda};
    assign w_byte_done = w_scl_rise && (r_bit_cnt == 4'd7);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // Next-state logic; STOP and START override any bit activity
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = c_st_idle;
        end else if (w_start) begin
            w_state_next = c_st_addr;
        end else begin
            case (r_state)
                c_st_addr: begin
                    if (w_byte_done) begin
                        if ((w_sr_next[7:1] == SLAVE_ADDR) && !w_sr_next[0])
                            w_state_next = c_st_addr_ack;
                        else
                            w_state_next = c_st_wait_stop;
                    end
                end
                // Second SCL fall of the ACK slot (sda_oe already set) ends it
                c_st_addr_ack, c_st_data_ack: begin
                    if (w_scl_fall && r_sda_oe) w_state_next = c_st_data;
                end
                c_st_data: begin
                    if (w_byte_done) w_state_next = c_st_data_ack;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Output decode from state
    always_comb begin
        w_busy = (r_state != c_st_idle);
    end

    // Datapath: shift register, bit counter, ACK drive and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= 4'd0;
            r_sr         <= 8'h00;
            r_sda_oe     <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_addr_match <= 1'b0;
            r_stop_det   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_stop_det   <= 1'b0;
            if (w_stop) begin
                r_sda_oe     <= 1'b0;
                r_addr_match <= 1'b0;
                r_bit_cnt    <= 4'd0;
                r_stop_det   <= 1'b1;
            end else if (w_start) begin
                r_sda_oe     <= 1'b0;
                r_addr_match <= 1'b0;
                r_bit_cnt    <= 4'd0;
            end else begin
                case (r_state)
                    c_st_addr, c_st_data: begin
                        if (w_scl_rise) begin
                            r_sr <= w_sr_next;
                            if (r_bit_cnt < 4'd8) r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_byte_done && (r_state == c_st_data)) begin
                                r_data_out   <= w_sr_next;
                                r_data_valid <= 1'b1;
                            end
                        end
                    end
                    c_st_addr_ack, c_st_data_ack: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe     <= 1'b1;
                                r_addr_match <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                            end
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe     = r_sda_oe;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign addr_match = r_addr_match;
    assign busy       = w_busy;
    assign stop_det   = r_stop_det;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_rx
// Purpose  : Self-checking bench for i2c_slave_rx. Table of single-byte write
//            transactions plus hand sequences for repeated START, partial
//            byte, reset during ACK and SCL glitch handling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addr_match;
    logic       busy;
    logic       stop_det;

    int tests_run    = 0;
    int tests_failed = 0;

    // Bus monitor state
    int         dv_cnt    = 0;
    int         stop_cnt  = 0;
    int         oe_viol   = 0;
    int         busy_drop = 0;
    logic       oe_mon_en = 1'b0;
    logic       busy_mon_en = 1'b0;
    logic       prev_oe   = 1'b0;
    logic [7:0] dv_q[$];

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data_byte;
        logic       exp_ack;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    // Open-drain bus: master pulls via m_sda, target pulls via sda_oe
    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(.SLAVE_ADDR(7'h42)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (m_scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_match (addr_match),
        .busy       (busy),
        .stop_det   (stop_det)
    );

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_q.push_back(data_out);
        end
        if (stop_det) stop_cnt <= stop_cnt + 1;
        if (oe_mon_en && (sda_oe != prev_oe) && m_scl) oe_viol <= oe_viol + 1;
        if (busy_mon_en && !busy) busy_drop <= busy_drop + 1;
        prev_oe <= sda_oe;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b0; wait_clk(10);
        m_scl = 1'b0; wait_clk(5);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wait_clk(5);
        m_scl = 1'b1; wait_clk(10);
        m_sda = 1'b0; wait_clk(10);
        m_scl = 1'b0; wait_clk(5);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(5);
        m_scl = 1'b1; wait_clk(10);
        m_sda = 1'b1; wait_clk(20);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clk(5);
        m_scl = 1'b1; wait_clk(10);
        m_scl = 1'b0; wait_clk(5);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Master releases SDA for the 9th clock and records the target's drive
    task automatic ack_slot(output logic oe_seen);
        m_sda = 1'b1; wait_clk(5);
        m_scl = 1'b1; wait_clk(5);
        @(negedge clk);
        oe_seen = sda_oe;
        wait_clk(5);
        m_scl = 1'b0; wait_clk(5);
    endtask

    initial begin
        logic       oe_a, oe_d, dummy;
        int         dv0, sd0, qbase;
        logic [7:0] v0, v1, exp_glitch;

        vecs[0] = '{8'h84, 8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h86, 8'h55, 1'b0, 8'hA5};
        vecs[2] = '{8'h85, 8'h3C, 1'b0, 8'hA5};
        vecs[3] = '{8'h84, 8'h00, 1'b1, 8'h00};
        vecs[4] = '{8'hC4, 8'h7E, 1'b0, 8'h00};
        vecs[5] = '{8'h84, 8'hFF, 1'b1, 8'hFF};

        // Reset with idle bus
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        wait_clk(2);
        @(negedge clk);
        check("rst_sda_oe",     sda_oe,     0);
        check("rst_data_out",   data_out,   0);
        check("rst_data_valid", data_valid, 0);
        check("rst_addr_match", addr_match, 0);
        check("rst_busy",       busy,       0);
        check("rst_stop_det",   stop_det,   0);
        rst = 1'b0;
        wait_clk(5);

        // Table of single-byte transactions
        oe_mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dv0 = dv_cnt; sd0 = stop_cnt;
            i2c_start();
            @(negedge clk);
            check($sformatf("v%0d_busy_start", i), busy, 1);
            send_byte(vecs[i].addr_byte);
            ack_slot(oe_a);
            check($sformatf("v%0d_addr_ack", i), oe_a, vecs[i].exp_ack);
            @(negedge clk);
            check($sformatf("v%0d_addr_match", i), addr_match, vecs[i].exp_ack);
            send_byte(vecs[i].data_byte);
            ack_slot(oe_d);
            check($sformatf("v%0d_data_ack", i), oe_d, vecs[i].exp_ack);
            i2c_stop();
            @(negedge clk);
            check($sformatf("v%0d_dv_count", i), dv_cnt - dv0, {31'd0, vecs[i].exp_ack});
            check($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_data);
            check($sformatf("v%0d_stop_det", i), stop_cnt - sd0, 1);
            check($sformatf("v%0d_busy_end", i), busy, 0);
            check($sformatf("v%0d_match_end", i), addr_match, 0);
            check($sformatf("v%0d_sda_oe_end", i), sda_oe, 0);
        end
        oe_mon_en = 1'b0;
        check("sda_oe_while_scl_high", oe_viol, 0);

        // Repeated START: two bytes delivered, busy held throughout
        dv0 = dv_cnt; qbase = dv_q.size();
        i2c_start();
        busy_mon_en = 1'b1;
        send_byte(8'h84); ack_slot(dummy);
        send_byte(8'h11); ack_slot(dummy);
        i2c_rstart();
        @(negedge clk);
        check("rs_match_cleared", addr_match, 0);
        check("rs_busy", busy, 1);
        send_byte(8'h84); ack_slot(oe_a);
        check("rs_addr_ack", oe_a, 1);
        send_byte(8'h22); ack_slot(dummy);
        busy_mon_en = 1'b0;
        i2c_stop();
        @(negedge clk);
        v0 = (dv_q.size() > qbase)     ? dv_q[qbase]     : 8'hxx;
        v1 = (dv_q.size() > qbase + 1) ? dv_q[qbase + 1] : 8'hxx;
        check("rs_dv_count", dv_cnt - dv0, 2);
        check("rs_byte0", v0, 8'h11);
        check("rs_byte1", v1, 8'h22);
        check("rs_busy_held", busy_drop, 0);
        check("rs_busy_end", busy, 0);

        // Partial byte before STOP is discarded
        dv0 = dv_cnt; sd0 = stop_cnt;
        i2c_start();
        send_byte(8'h84); ack_slot(dummy);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        @(negedge clk);
        check("partial_no_dv", dv_cnt - dv0, 0);
        check("partial_stop_det", stop_cnt - sd0, 1);
        check("partial_data_out", data_out, 8'h22);

        // Reset during the ACK slot releases SDA on the next clock
        i2c_start();
        send_byte(8'h84);
        m_sda = 1'b1; wait_clk(5);
        m_scl = 1'b1; wait_clk(2);
        @(negedge clk);
        check("rstack_oe_before", sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstack_oe_after", sda_oe, 0);
        check("rstack_busy", busy, 0);
        check("rstack_match", addr_match, 0);
        rst = 1'b0;
        wait_clk(3);
        m_scl = 1'b0; wait_clk(5);
        i2c_stop();

        // 2-clk SCL glitch inside a data byte
`ifdef I2C_GLITCH_FILTER_EN
        exp_glitch = 8'h5A;
`else
        exp_glitch = 8'hAD;
`endif
        dv0 = dv_cnt;
        i2c_start();
        send_byte(8'h84); ack_slot(dummy);
        m_sda = 1'b1; wait_clk(2);
        m_scl = 1'b1; wait_clk(2);
        m_scl = 1'b0; wait_clk(4);
        send_byte(8'h5A); ack_slot(dummy);
        i2c_stop();
        @(negedge clk);
        check("glitch_dv_count", dv_cnt - dv0, 1);
        check("glitch_data", data_out, exp_glitch);
        check("glitch_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
